// File: rtl/ddr_sched_pkg.sv
// Shared definitions for the channel backend schedulers.
// Contents:
//   chan_mode_e - channel mode / bus turnaround state encoding
//   occ_sum_w   - width of a sum of per-rank occupancy counts
//   sat_cnt_w   - width of a counter that saturates at a given limit
package ddr_sched_pkg;

  typedef enum logic [1:0] {
    MODE_READ  = 2'd0,
    MODE_RD2WR = 2'd1,
    MODE_WRITE = 2'd2,
    MODE_WR2RD = 2'd3
  } chan_mode_e;

  // Each rank reports a $clog2(depth)-bit count; summing NUMRANK of them
  // needs $clog2(NUMRANK) extra bits so the total can never wrap.
  function automatic int occ_sum_w(input int depth, input int nrank);
    return $clog2(depth) + $clog2(nrank);
  endfunction

  function automatic int sat_cnt_w(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/channel_mode_scheduler_turnaround_timer.sv
// turnaround_timer: loadable down-counter timing a bus turnaround window.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (count cleared)
//   load      - load loadVal into the counter this cycle
//   loadVal   - window length in cycles
//   expired   - high during the last cycle of the window (count == 1)
module turnaround_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] loadVal,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= loadVal;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  // Idles at zero in the steady states, so expired never fires there.
  assign expired = (count == W'(1));

endmodule

// File: rtl/channel_mode_scheduler.sv
// channel_mode_scheduler: channel-level READ/WRITE mode controller.
// Chooses when to drain write queues (watermarks on total write occupancy,
// read starvation of writes, write burst limit) and blocks column commands
// during the read-to-write and write-to-read bus turnaround windows.
// Ports:
//   clk, rst     - channel clock, synchronous active-high reset
//   readReqCnt   - per-rank read queue occupancy
//   writeReqCnt  - per-rank write queue occupancy
//   casIssued    - one-cycle pulse per column command on the channel
//   casIsWrite   - qualifies casIssued: 1 = write CAS
//   writeMode    - registered channel mode, 1 = write
//   casBlock     - registered, column commands prohibited (turnaround)
//   modeSwitch   - registered one-cycle pulse when writeMode toggles
module channel_mode_scheduler
  import ddr_sched_pkg::*;
#(
  parameter int NUMRANK            = 4,
  parameter int READCMDQUEUEDEPTH  = 8,
  parameter int WRITECMDQUEUEDEPTH = 8,
  parameter int WRHIGHWM           = 12,
  parameter int WRLOWWM            = 4,
  parameter int TRTW               = 6,
  parameter int TWTR               = 8,
  parameter int MAXWRBURST         = 16,
  parameter int WRSTARVELIMIT      = 64
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic [NUMRANK-1:0][$clog2(READCMDQUEUEDEPTH)-1:0]  readReqCnt,
  input  logic [NUMRANK-1:0][$clog2(WRITECMDQUEUEDEPTH)-1:0] writeReqCnt,
  input  logic                                               casIssued,
  input  logic                                               casIsWrite,
  output logic                                               writeMode,
  output logic                                               casBlock,
  output logic                                               modeSwitch
);

  localparam int RSUM_W   = occ_sum_w(READCMDQUEUEDEPTH, NUMRANK);
  localparam int WSUM_W   = occ_sum_w(WRITECMDQUEUEDEPTH, NUMRANK);
  localparam int STV_W    = sat_cnt_w(WRSTARVELIMIT);
  localparam int BST_W    = sat_cnt_w(MAXWRBURST);
  localparam int TRTW_EFF = (TRTW < 1) ? 1 : TRTW;
  localparam int TWTR_EFF = (TWTR < 1) ? 1 : TWTR;
  localparam int TMR_MAX  = (TRTW_EFF > TWTR_EFF) ? TRTW_EFF : TWTR_EFF;
  localparam int TMR_W    = $clog2(TMR_MAX + 1);

  localparam logic [WSUM_W-1:0] HIGH_WM = WSUM_W'(WRHIGHWM);
  localparam logic [WSUM_W-1:0] LOW_WM  = WSUM_W'(WRLOWWM);
  localparam logic [STV_W-1:0]  STV_LIM = STV_W'(WRSTARVELIMIT);
  localparam logic [BST_W-1:0]  BST_LIM = BST_W'(MAXWRBURST);

  if (!(WRLOWWM < WRHIGHWM && WRHIGHWM <= NUMRANK * (WRITECMDQUEUEDEPTH - 1))) begin : g_bad_wm
    $error("channel_mode_scheduler: need WRLOWWM < WRHIGHWM <= NUMRANK*(WRITECMDQUEUEDEPTH-1)");
  end

  logic [RSUM_W-1:0] rdTotal;
  logic [WSUM_W-1:0] wrTotal;
  chan_mode_e        state, state_nxt;
  logic [STV_W-1:0]  starve, starve_nxt;
  logic [BST_W-1:0]  wrBurst, wrBurst_nxt;
  logic              tmr_load, tmr_expired;
  logic [TMR_W-1:0]  tmr_val;

  always_comb begin
    rdTotal = '0;
    wrTotal = '0;
    for (int i = 0; i < NUMRANK; i++) begin
      rdTotal = rdTotal + RSUM_W'(readReqCnt[i]);
      wrTotal = wrTotal + WSUM_W'(writeReqCnt[i]);
    end
  end

  turnaround_timer #(.W(TMR_W)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .loadVal (tmr_val),
    .expired (tmr_expired)
  );

  // Starvation and burst limits compare against the count including the
  // current cycle, so the switch lands exactly on the limiting cycle/CAS.
  always_comb begin
    state_nxt   = state;
    starve_nxt  = starve;
    wrBurst_nxt = wrBurst;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    unique case (state)
      MODE_READ: begin
        if (wrTotal == '0)          starve_nxt = '0;
        else if (starve >= STV_LIM) starve_nxt = STV_LIM;
        else                        starve_nxt = starve + 1'b1;
        if (wrTotal >= HIGH_WM || (rdTotal == '0 && wrTotal != '0) ||
            starve_nxt >= STV_LIM) begin
          state_nxt  = MODE_RD2WR;
          starve_nxt = '0;
          tmr_load   = 1'b1;
          tmr_val    = TMR_W'(TRTW_EFF);
        end
      end
      MODE_RD2WR: begin
        if (tmr_expired) begin
          state_nxt   = MODE_WRITE;
          wrBurst_nxt = '0;
        end
      end
      MODE_WRITE: begin
        if (casIssued && casIsWrite && wrBurst < BST_LIM)
          wrBurst_nxt = wrBurst + 1'b1;
        if (rdTotal != '0 &&
            (wrTotal <= LOW_WM || wrTotal == '0 || wrBurst_nxt >= BST_LIM)) begin
          state_nxt = MODE_WR2RD;
          tmr_load  = 1'b1;
          tmr_val   = TMR_W'(TWTR_EFF);
        end
      end
      MODE_WR2RD: begin
        if (tmr_expired) state_nxt = MODE_READ;
      end
      default: state_nxt = MODE_READ;
    endcase
  end

  // Outputs decode next-state so they change on the same edge as state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= MODE_READ;
      starve     <= '0;
      wrBurst    <= '0;
      writeMode  <= 1'b0;
      casBlock   <= 1'b0;
      modeSwitch <= 1'b0;
    end else begin
      state      <= state_nxt;
      starve     <= starve_nxt;
      wrBurst    <= wrBurst_nxt;
      writeMode  <= (state_nxt == MODE_RD2WR) || (state_nxt == MODE_WRITE);
      casBlock   <= (state_nxt == MODE_RD2WR) || (state_nxt == MODE_WR2RD);
      modeSwitch <= (state_nxt != state) &&
                    ((state_nxt == MODE_RD2WR) || (state_nxt == MODE_WR2RD));
    end
  end

  // A column command during a turnaround window is a protocol violation.
  a_no_cas_in_turnaround: assert property (
    @(posedge clk) disable iff (rst) !(casIssued && casBlock));

endmodule

// File: tb/tb_channel_mode_scheduler.sv
module tb_channel_mode_scheduler;

  localparam int NUMRANK = 4;
  localparam int RD_D    = 8;
  localparam int WR_D    = 8;
  localparam int RCW     = $clog2(RD_D);
  localparam int WCW     = $clog2(WR_D);
  localparam int HIGHWM  = 12;
  localparam int LOWWM   = 4;
  localparam int RTW     = 6;
  localparam int WTR     = 8;
  localparam int BURST   = 16;
  localparam int STARVE  = 64;

  logic                          clk = 1'b0;
  logic                          rst;
  logic [NUMRANK-1:0][RCW-1:0]   readReqCnt;
  logic [NUMRANK-1:0][WCW-1:0]   writeReqCnt;
  logic                          casIssued;
  logic                          casIsWrite;
  logic                          writeMode;
  logic                          casBlock;
  logic                          modeSwitch;

  channel_mode_scheduler #(
    .NUMRANK(NUMRANK), .READCMDQUEUEDEPTH(RD_D), .WRITECMDQUEUEDEPTH(WR_D),
    .WRHIGHWM(HIGHWM), .WRLOWWM(LOWWM), .TRTW(RTW), .TWTR(WTR),
    .MAXWRBURST(BURST), .WRSTARVELIMIT(STARVE)
  ) dut (
    .clk(clk), .rst(rst), .readReqCnt(readReqCnt), .writeReqCnt(writeReqCnt),
    .casIssued(casIssued), .casIsWrite(casIsWrite),
    .writeMode(writeMode), .casBlock(casBlock), .modeSwitch(modeSwitch)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: the channel is either in read or write mode,
  // possibly with some turnaround cycles still to run.
  bit m_valid = 0;
  bit m_wm;
  bit m_sw;
  int m_left;
  int m_pend;
  int m_burst;

  always @(posedge clk) begin
    int rd, wr;
    rd = 0;
    wr = 0;
    for (int i = 0; i < NUMRANK; i++) begin
      rd += int'(readReqCnt[i]);
      wr += int'(writeReqCnt[i]);
    end
    if (rst) begin
      m_valid = 1;
      m_wm = 0; m_sw = 0; m_left = 0; m_pend = 0; m_burst = 0;
    end else if (m_valid) begin
      m_sw = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0 && m_wm) m_burst = 0;
      end else if (!m_wm) begin
        m_pend = (wr == 0) ? 0 : ((m_pend + 1 > STARVE) ? STARVE : m_pend + 1);
        if (wr >= HIGHWM || (rd == 0 && wr != 0) || m_pend >= STARVE) begin
          m_wm = 1; m_left = RTW; m_pend = 0; m_sw = 1;
        end
      end else begin
        if (casIssued && casIsWrite && m_burst < BURST) m_burst++;
        if (rd != 0 && (wr <= LOWWM || m_burst >= BURST)) begin
          m_wm = 0; m_left = WTR; m_sw = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_writeMode", writeMode, m_wm);
      check("model_casBlock", casBlock, m_left > 0);
      check("model_modeSwitch", modeSwitch, m_sw);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_rd(input int total);
    int t, v;
    t = total;
    for (int i = 0; i < NUMRANK; i++) begin
      v = (t > RD_D - 1) ? RD_D - 1 : t;
      readReqCnt[i] = RCW'(v);
      t -= v;
    end
  endtask

  task automatic set_wr(input int total);
    int t, v;
    t = total;
    for (int i = 0; i < NUMRANK; i++) begin
      v = (t > WR_D - 1) ? WR_D - 1 : t;
      writeReqCnt[i] = WCW'(v);
      t -= v;
    end
  endtask

  task automatic wait_unblocked(input string name);
    int n;
    n = 0;
    while (casBlock && n < 50) begin
      step();
      n++;
    end
    check(name, casBlock, 0);
  endtask

  function automatic int pick_max();
    case ($urandom_range(0, 3))
      0:       return 0;
      1:       return 1;
      2:       return 3;
      default: return 7;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int n, pulses, rmax, wmax;
    rst = 1'b1;
    readReqCnt = '0;
    writeReqCnt = '0;
    casIssued = 1'b0;
    casIsWrite = 1'b0;
    repeat (3) step();
    check("reset_writeMode", writeMode, 0);
    check("reset_casBlock", casBlock, 0);
    check("reset_modeSwitch", modeSwitch, 0);
    rst = 1'b0;

    // Idle: nothing queued, nothing may move.
    pulses = 0;
    repeat (20) begin
      step();
      pulses += int'(modeSwitch);
    end
    check("idle_switches", pulses, 0);
    check("idle_writeMode", writeMode, 0);

    // High watermark with reads pending.
    set_rd(5);
    step();
    set_wr(12);
    step();
    check("hwm_switch", modeSwitch, 1);
    check("hwm_block", casBlock, 1);
    check("hwm_writeMode", writeMode, 1);
    n = 0;
    while (casBlock && n < 20) begin n++; step(); end
    check("rtw_block_cycles", n, 6);
    check("hwm_in_write", writeMode, 1);

    // Drain writes down to the low watermark.
    set_rd(3);
    for (int k = 1; k <= 8; k++) begin
      set_wr(12 - k);
      casIssued = 1'b1;
      casIsWrite = 1'b1;
      step();
      casIssued = 1'b0;
      if (k < 8) check("drain_hold_writeMode", writeMode, 1);
    end
    check("lwm_writeMode", writeMode, 0);
    check("lwm_block", casBlock, 1);
    check("lwm_switch", modeSwitch, 1);
    set_wr(0);
    n = 0;
    while (casBlock && n < 20) begin n++; step(); end
    check("wtr_block_cycles", n, 8);
    step();
    step();

    // Starvation: one pending write, reads always pending.
    set_wr(1);
    n = 0;
    do begin step(); n++; end while (!modeSwitch && n < 200);
    check("starve_cycles", n, 64);
    check("starve_writeMode", writeMode, 1);

    // Write burst limit with reads pending.
    set_rd(2);
    set_wr(10);
    wait_unblocked("burst_enter_timeout");
    check("burst_in_write", writeMode, 1);
    pulses = 0;
    for (int k = 1; k <= 16; k++) begin
      casIssued = 1'b1;
      casIsWrite = 1'b1;
      step();
      casIssued = 1'b0;
      if (k < 16) pulses += int'(modeSwitch);
    end
    check("burst_early_switch", pulses, 0);
    check("burst_exit_switch", modeSwitch, 1);
    check("burst_exit_writeMode", writeMode, 0);

    // Same traffic with no reads: write mode must hold.
    set_rd(0);
    wait_unblocked("wr2rd_timeout");
    step();
    check("empty_rd_switch", modeSwitch, 1);
    wait_unblocked("rd2wr_timeout");
    pulses = 0;
    repeat (20) begin
      casIssued = 1'b1;
      casIsWrite = 1'b1;
      step();
      casIssued = 1'b0;
      pulses += int'(modeSwitch);
    end
    check("noread_switches", pulses, 0);
    check("noread_writeMode", writeMode, 1);

    // Reset in the middle of a read-to-write turnaround.
    set_rd(2);
    set_wr(4);
    step();
    check("pre_rst_switch", modeSwitch, 1);
    wait_unblocked("pre_rst_timeout");
    set_rd(5);
    set_wr(12);
    step();
    check("rst_rd2wr_enter", modeSwitch, 1);
    repeat (3) step();
    check("rst_mid_block", casBlock, 1);
    rst = 1'b1;
    step();
    check("rst_mid_writeMode", writeMode, 0);
    check("rst_mid_casBlock", casBlock, 0);
    check("rst_mid_modeSwitch", modeSwitch, 0);
    rst = 1'b0;
    step();
    check("post_rst_switch", modeSwitch, 1);
    check("post_rst_writeMode", writeMode, 1);

    // Randomised traffic against the model.
    rmax = 3;
    wmax = 3;
    for (int c = 0; c < 3000; c++) begin
      if (c % 40 == 0) begin
        rmax = pick_max();
        wmax = pick_max();
      end
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < NUMRANK; i++) begin
          readReqCnt[i]  = RCW'($urandom_range(0, rmax));
          writeReqCnt[i] = WCW'($urandom_range(0, wmax));
        end
      end
      rst = ($urandom_range(0, 299) == 0);
      casIssued  = (m_left == 0) && !rst && ($urandom_range(0, 1) == 1);
      casIsWrite = ($urandom_range(0, 3) != 0);
      step();
    end
    rst = 1'b0;
    casIssued = 1'b0;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/channel_mode_scheduler.md
Name: channel_mode_scheduler

Overview:
- Channel-level READ/WRITE mode controller. Produces the writeMode signal consumed by CMDGrantScheduler and the RankControllers.
- Decides when to drain write queues, using watermarks on total per-rank queue occupancy plus starvation limits.
- Enforces read-to-write (tRTW) and write-to-read (tWTR) bus turnaround windows by blocking column commands.
- Sits in the channel backend beside CMDGrantScheduler, one instance per channel.

Parameters:
- NUMRANK, 4, number of RankControllers on the channel.
- READCMDQUEUEDEPTH, 8, per-rank read queue depth; sets readReqCnt width.
- WRITECMDQUEUEDEPTH, 8, per-rank write queue depth; sets writeReqCnt width.
- WRHIGHWM, 12, total write occupancy that forces entry to write mode.
- WRLOWWM, 4, total write occupancy at or below which write mode may end.
- TRTW, 6, cycles column commands are blocked on a read-to-write switch.
- TWTR, 8, cycles column commands are blocked on a write-to-read switch.
- MAXWRBURST, 16, maximum write CAS count per write phase while reads are pending.
- WRSTARVELIMIT, 64, maximum READ-state cycles with writes pending before a forced switch.

Ports:
- clk, input, 1, channel clock.
- rst, input, 1, synchronous, active-high reset.
- readReqCnt, input, [$clog2(READCMDQUEUEDEPTH)-1:0] x NUMRANK, per-rank read occupancy.
- writeReqCnt, input, [$clog2(WRITECMDQUEUEDEPTH)-1:0] x NUMRANK, per-rank write occupancy.
- casIssued, input, 1, one-cycle pulse per column command issued on the channel.
- casIsWrite, input, 1, qualifies casIssued: 1 = write CAS.
- writeMode, output, 1, channel mode: 1 = write.
- casBlock, output, 1, column commands prohibited (turnaround window).
- modeSwitch, output, 1, one-cycle pulse on the cycle writeMode toggles.

Behaviour:
- Occupancy totals:
  - rdTotal and wrTotal are combinational sums over all ranks.
  - Sum width = count width + $clog2(NUMRANK); no overflow is possible.
- States: READ, RD2WR, WRITE, WR2RD, held in a registered state register.
- Reset (rst high at a clk edge, including mid-turnaround):
  - state=READ, timer=0, wrBurst=0, starve=0.
  - writeMode=0, casBlock=0, modeSwitch=0.
- Outputs are registered (decoded from next-state), so they update the cycle the state changes:
  - writeMode=1 in RD2WR and WRITE; 0 in READ and WR2RD.
  - casBlock=1 in RD2WR and WR2RD only.
  - modeSwitch=1 for exactly one cycle, the first cycle of RD2WR or WR2RD.
- READ -> RD2WR when any of the following holds (evaluated every cycle):
  - wrTotal >= WRHIGHWM, or
  - rdTotal==0 and wrTotal!=0, or
  - starve >= WRSTARVELIMIT.
  - On the transition, load timer=max(TRTW,1) and clear starve.
- starve counter:
  - Increments in READ when wrTotal!=0; clears when wrTotal==0.
  - Saturates at WRSTARVELIMIT.
- RD2WR:
  - timer decrements each cycle; go to WRITE on the cycle timer==1.
  - Dwell is exactly max(TRTW,1) cycles. Clear wrBurst on entry to WRITE.
- WRITE -> WR2RD when rdTotal!=0 and any of the following holds:
  - wrTotal <= WRLOWWM, or
  - wrTotal==0, or
  - wrBurst >= MAXWRBURST.
  - On the transition, load timer=max(TWTR,1).
- wrBurst counter:
  - Increments on casIssued & casIsWrite in WRITE; saturates at MAXWRBURST.
- WR2RD: same countdown as RD2WR, then go to READ.
- Both totals zero: remain in the current steady state (READ or WRITE); no spurious switch.
- Turnaround states are non-interruptible. Occupancy changes during RD2WR/WR2RD are ignored until the steady state is reached.
- casIssued while casBlock=1 is a protocol violation:
  - Assertion fires.
  - State is unaffected; the CAS is not counted.
- casIssued in the same cycle as a WRITE->WR2RD decision: the CAS is counted and the transition still occurs.
- The watermark condition has priority over the starvation condition only for reporting; all READ exit conditions take the same transition.
- Elaboration check: WRLOWWM < WRHIGHWM <= NUMRANK*(WRITECMDQUEUEDEPTH-1).

Decomposition:
- Shared package ddr_sched_pkg:
  - typedef enum logic [1:0] chan_mode_e {MODE_READ, MODE_RD2WR, MODE_WRITE, MODE_WR2RD}.
  - Localparam width helpers for occupancy sums.
- One sub-module, turnaround_timer:
  - Loadable down-counter with load, loadVal and expired outputs.
  - Instantiated once; shared by both turnaround states.

Test Plan:
- Reset then idle, all counts 0 for 20 cycles -> writeMode=0, casBlock=0, modeSwitch never pulses.
- Reads pending (rdTotal=5); wrTotal rises to 12 at cycle T -> modeSwitch and casBlock high at T+1; casBlock held 6 cycles; writeMode=1 from T+1.
- In WRITE with rdTotal=3, issue write CASes until wrTotal drops to 4 -> WR2RD entered next cycle; casBlock=1 for 8 cycles; writeMode=0 on that same entry cycle.
- READ with wrTotal=1 constant and reads always pending -> forced switch after exactly 64 cycles (starvation).
- WRITE with wrTotal=10 constant, rdTotal=2, 16 write CASes -> exit on the 16th CAS; rdTotal=0 with the same traffic -> stays in WRITE.
- Assert rst during RD2WR at timer=3 -> next cycle state=READ, all outputs 0; watermarks re-evaluated normally afterward.
